uart_tx_frame_ctrl: RTL

- Frame controller for the UART TX path. It accepts a byte request and sequences the start bit, data bits, optional parity and stop bit.
- Drives ser_en to the bit serializer and consumes its ser_data/ser_done. Owns the registered TX line.
- Computes parity on accept. Detects a serializer that never signals done.

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_parity_calc.sv | 22 ++
 rtl/uart_tx_frame_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and constants for the UART TX frame controller.
//   state_e    : frame sequencer states. STOP2 exists only when the macro
//                UART_TX_TWO_STOP_EN is defined (second stop bit).
//   LINE_*     : UART line levels for idle/stop and start bit.
//   PAR_*      : parity-type encodings of the PAR_TYP input.
// ---------------------------------------------------------------------------
package uart_tx_pkg;

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`endif

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// ---------------------------------------------------------------------------
// uart_parity_calc
// Combinational parity of one data word. The result is the bit that makes
// the total count of ones (data + parity) even for PAR_EVEN, odd for PAR_ODD.
// Ports:
//   data    in  [DATA_WIDTH-1:0]  word to protect
//   par_typ in  1                 PAR_EVEN / PAR_ODD
//   parity  out 1                 parity bit to transmit
// ---------------------------------------------------------------------------
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_ctrl
// Frame sequencer for the UART TX path: start bit, DATA_WIDTH data bits
// supplied by an external serializer, optional parity, stop bit(s).
// A watchdog aborts the frame if the serializer never reports ser_done.
// Build option: define UART_TX_TWO_STOP_EN to append a second stop bit.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   Data_valid  byte request, accepted in IDLE or in the last stop cycle
//   P_data      byte to send, sampled on accept
//   PAR_EN      insert a parity bit (latched on accept)
//   PAR_TYP     0 = even, 1 = odd (folded into latched parity on accept)
//   ser_data    current data bit from the serializer
//   ser_done    serializer is presenting its last bit
//   ser_en      serializer advance enable (combinational from state)
//   tx_out      registered UART line
//   busy        frame in progress (registered)
//   frame_err   one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WDOG_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Data_valid,
  input  logic [DATA_WIDTH-1:0] P_data,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int WDOG_LIMIT = DATA_WIDTH + WDOG_SLACK;
  localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

  state_e              state_q, state_d;
  logic                tx_out_q, tx_out_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic                par_en_q, par_en_d;
  logic                parity_q, parity_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                parity_calc;
  logic                accept;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_data),
    .par_typ (PAR_TYP),
    .parity  (parity_calc)
  );

  assign wdog_inc = wdog_q + 1'b1;

  // tx_out_d is the line value for the current state; it is registered so
  // the line lags the state by exactly one clock and never glitches.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    tx_out_d    = LINE_IDLE;
    frame_err_d = 1'b0;
    par_en_d    = par_en_q;
    parity_d    = parity_q;
    wdog_d      = wdog_q;
    ser_en      = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept = Data_valid;
      end

      START: begin
        tx_out_d = LINE_START;
        ser_en   = 1'b1;          // serializer loads bit 0 for the first DATA cycle
        wdog_d   = '0;
        state_d  = DATA;
      end

      DATA: begin
        tx_out_d = ser_data;
        ser_en   = ~ser_done;
        wdog_d   = wdog_inc;
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end else if (wdog_inc == WDOG_W'(WDOG_LIMIT)) begin
          // Serializer is stuck: drop the frame and park the line high.
          state_d     = IDLE;
          frame_err_d = 1'b1;
          ser_en      = 1'b0;
          tx_out_d    = LINE_IDLE;
        end
      end

      PARITY: begin
        tx_out_d = parity_q;
        state_d  = STOP;
      end

`ifdef UART_TX_TWO_STOP_EN
      STOP: begin
        state_d = STOP2;
      end

      STOP2: begin
        state_d = IDLE;
        accept  = Data_valid;     // last stop cycle: back-to-back accept
      end
`else
      STOP: begin
        state_d = IDLE;
        accept  = Data_valid;     // last stop cycle: back-to-back accept
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d  = START;
      par_en_d = PAR_EN;
      parity_d = parity_calc;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_out_q    <= LINE_IDLE;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      par_en_q    <= 1'b0;
      parity_q    <= 1'b0;
      wdog_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      tx_out_q    <= tx_out_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      par_en_q    <= par_en_d;
      parity_q    <= parity_d;
      wdog_q      <= wdog_d;
    end
  end

  assign tx_out    = tx_out_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
